instruction_loader: RTL and testbench
=====================================

# instruction_loader

Program loader that packs 3-bit opcode / 5-bit address pairs into 8-bit instruction words (opcode in bits 7:5, address in bits 4:0) and writes them to consecutive instruction-memory locations starting at 0. It sits between the host/boot stream and the instruction memory. It is the write-side counterpart of the fetch stage that splits each stored byte back into opcode and address. A valid/ready handshake on the input side lets the source stall freely.

## Interface
- MEM_DEPTH, 32, number of instruction-memory locations; range 2..32.
- ADDR_W, 5, write-address width; MEM_DEPTH ≤ 2**ADDR_W.
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin a load session; sampled only in IDLE.
- In_Valid  input  1  source presents a word.
- In_Opcode  input  3  opcode field.
- In_Address  input  5  operand address field.
- In_Last  input  1  marks the final word of the program.
- In_Ready  output  1  loader accepts a word this cycle.
- Wr_En  output  1  memory write strobe.
- Wr_Addr  output  ADDR_W  memory write address.
- Wr_Data  output  8  packed word, {opcode, address}.
- Busy  output  1  session in progress.
- Done  output  1  one-cycle pulse when the session ends.
- Overflow  output  1  sticky flag: the program exceeded MEM_DEPTH.
- Count  output  ADDR_W+1  number of words written this session.

## Operation
- The FSM has three states: IDLE, LOAD and FINISH.
- IDLE:
  - Start=1 moves to LOAD and clears the write pointer, Count and Overflow.
  - In_Valid is ignored.
- LOAD:
  - In_Ready=1.
  - A word is accepted when In_Valid & In_Ready.
  - On accept, register Wr_Data={In_Opcode,In_Address} and Wr_Addr=pointer, set Wr_En=1 for one cycle, and increment both pointer and Count.
- LOAD to FINISH happens on an accept when either condition holds:
  - In_Last=1.
  - The pointer equals MEM_DEPTH-1, i.e. the memory is full. If In_Last=0 in this case, set Overflow=1.
- FINISH:
  - In_Ready=0 and Done=1 for exactly one cycle, then go to IDLE.
  - The pointer does not wrap; further words are never written.
- Start while in LOAD or FINISH is ignored.
- Busy = (state != IDLE).
- Reset at any time, including mid-session:
  - Returns to IDLE.
  - Writes already issued stand. No further Wr_En is issued, including any write registered at that edge.
- Overflow and Count hold their values in IDLE until the next Start or Reset.
- All outputs are registered except In_Ready and Busy, which decode the state register.

## Timing
- Reset values:
  - State IDLE, In_Ready=0, Busy=0.
  - Wr_En=0, Wr_Addr=0, Wr_Data=8'h00.
  - Done=0, Overflow=0, Count=0.
- Start sampled at edge E: In_Ready=1 from cycle E+1.
- Write latency is one cycle. A word accepted at edge N appears with Wr_En=1 during cycle N+1, and Count reflects it from N+1.
- Back-to-back accepts give back-to-back writes at consecutive addresses, one word per cycle.
- Final accept at edge N:
  - Cycle N+1 carries both the final Wr_En and Done=1.
  - State is IDLE and Busy=0 at N+2.
  - The minimum session is 1 cycle of Start plus 1 accept plus 1 cycle of FINISH.
- Wr_Addr and Wr_Data hold their last values while Wr_En=0.

## Structure
- A shared package cpu_pkg holds:
  - OPCODE_W=3, OPADDR_W=5, INSTR_W=8.
  - Field positions OPC_MSB=7, OPC_LSB=5.
  - The loader state enum (IDLE, LOAD, FINISH).
- The fetch-side splitter uses the same field constants.
- No sub-module: packing is a single concatenation, and the FSM plus pointer fits in one block.

## Test plan
- Reset mid-session:
  - Stimulus: after 3 writes, assert Reset for one cycle.
  - Required: all outputs return to reset values, no further Wr_En, and Start restarts at address 0.
- Basic load:
  - Stimulus: Start, then 4 words (opcode 3'b001 addr 5'd10, 3'b010 addr 5'd11, 3'b111 addr 5'd0, 3'b000 addr 5'd31 with In_Last).
  - Required: writes 8'h2A@0, 8'h4B@1, 8'hE0@2, 8'h1F@3 on consecutive cycles. Done pulses with the 4th write, Count=4, Overflow=0.
- Stalls:
  - Stimulus: In_Valid toggles 1,0,0,1,1 with words 8'hA1, 8'hA2, 8'hA3.
  - Required: writes at addresses 0, 1, 2 only in the cycles after each accept, with no write during gaps.
- Full, exact fit:
  - Stimulus: 32 words, with In_Last on the 32nd.
  - Required: addresses 0..31 written, Count=32, Done=1, Overflow=0.
- Overflow:
  - Stimulus: 33 words with no In_Last.
  - Required: 32 writes, In_Ready drops after the 32nd accept, Overflow=1 and sticky, the 33rd word is not written, and Overflow clears on the next Start.
- Ignored Start:
  - Stimulus: pulse Start while in LOAD after 2 words.
  - Required: pointer continues at 2 and Count is not cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout used by both the loader
// (packing) and the fetch stage (splitting), plus the loader state encoding.
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int OPADDR_W = 5;
  localparam int INSTR_W  = 8;
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// Packs {opcode, address} pairs from a valid/ready stream into consecutive
// instruction-memory words starting at address 0, one session per Start.
module instruction_loader
  import cpu_pkg::*;
#(
  parameter int MEM_DEPTH = 32,
  parameter int ADDR_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_in_valid,
  input  logic [OPCODE_W-1:0] i_in_opcode,
  input  logic [OPADDR_W-1:0] i_in_address,
  input  logic                i_in_last,
  output logic                o_in_ready,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [INSTR_W-1:0]  o_wr_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [ADDR_W:0]     o_count
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);

  loader_state_t        r_state;
  loader_state_t        w_next_state;
  logic [ADDR_W-1:0]    r_ptr;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [INSTR_W-1:0]   r_wr_data;
  logic                 r_done;
  logic                 r_overflow;
  logic [ADDR_W:0]      r_count;
  logic                 w_accept;
  logic                 w_full;
  logic                 w_end;
  logic [INSTR_W-1:0]   w_instr;

  assign w_accept = i_in_valid & o_in_ready;
  assign w_full   = (r_ptr == LAST_PTR);
  // A session ends on the last word or when the final memory slot is taken.
  assign w_end    = w_accept & (i_in_last | w_full);

  always_comb begin
    w_instr                  = '0;
    w_instr[OPC_MSB:OPC_LSB] = i_in_opcode;
    w_instr[OPC_LSB-1:0]     = i_in_address;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path leaves the signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = LOAD;
      LOAD:    if (w_end)   w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == LOAD);
    o_busy     = (r_state != IDLE);
  end

  // NOTE: the reset branch also clears the write strobe, so a word accepted
  // on the reset edge is dropped rather than written.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_wr_en <= w_accept;
      r_done  <= w_end;
      if (r_state == IDLE && i_start) begin
        r_ptr      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end
      if (w_accept) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_instr;
        r_count   <= r_count + 1'b1;
        // The pointer parks on the last slot instead of wrapping to 0.
        if (!w_full) r_ptr <= r_ptr + 1'b1;
        if (w_full && !i_in_last) r_overflow <= 1'b1;
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_count    = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table-driven basic load, hand-written corner
// sequences, and randomized sessions scored against a word-list model.
module tb_instruction_loader;
  import cpu_pkg::*;

  localparam int MEM_DEPTH = 32;
  localparam int ADDR_W    = 5;

  logic                i_clk;
  logic                i_reset;
  logic                i_start;
  logic                i_in_valid;
  logic [OPCODE_W-1:0] i_in_opcode;
  logic [OPADDR_W-1:0] i_in_address;
  logic                i_in_last;
  logic                o_in_ready;
  logic                o_wr_en;
  logic [ADDR_W-1:0]   o_wr_addr;
  logic [INSTR_W-1:0]  o_wr_data;
  logic                o_busy;
  logic                o_done;
  logic                o_overflow;
  logic [ADDR_W:0]     o_count;

  instruction_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_in_valid  (i_in_valid),
    .i_in_opcode (i_in_opcode),
    .i_in_address(i_in_address),
    .i_in_last   (i_in_last),
    .o_in_ready  (o_in_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_overflow  (o_overflow),
    .o_count     (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  // Write/done monitor, sampled on the falling edge.
  typedef struct { int addr; int data; int c; } wr_t;
  wr_t wlog[$];
  int  done_cnt = 0;
  int  done_cyc = 0;
  always @(negedge i_clk) begin
    if (o_wr_en) wlog.push_back('{int'(o_wr_addr), int'(o_wr_data), cyc});
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] opc, input logic [4:0] adr, input logic last);
    i_in_valid   = v;
    i_in_opcode  = opc;
    i_in_address = adr;
    i_in_last    = last;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},    32'(o_in_ready), 0);
    check({tag, "_busy"},     32'(o_busy),     0);
    check({tag, "_wr_en"},    32'(o_wr_en),    0);
    check({tag, "_wr_addr"},  32'(o_wr_addr),  0);
    check({tag, "_wr_data"},  32'(o_wr_data),  0);
    check({tag, "_done"},     32'(o_done),     0);
    check({tag, "_overflow"}, 32'(o_overflow), 0);
    check({tag, "_count"},    32'(o_count),    0);
  endtask

  // Source program for model-checked sessions.
  logic [2:0] s_opc [64];
  logic [4:0] s_adr [64];
  logic       s_last[64];
  int         s_n;

  task automatic fill(input int n, input int last_idx);
    s_n = n;
    for (int i = 0; i < n; i++) begin
      s_opc[i]  = 3'($urandom);
      s_adr[i]  = 5'($urandom);
      s_last[i] = (i == last_idx);
    end
  endtask

  // Offers the program with random stalls; the model says the loader keeps
  // words up to and including the first In_Last, capped at MEM_DEPTH.
  task automatic run_session(input int stall_pct, input string name);
    int acc_cyc[$];
    int base, dbase, idx, budget, k;
    logic v, acc, exp_ovf;
    base  = wlog.size();
    dbase = done_cnt;
    pulse_start();
    check({name, "_ready_after_start"}, 32'(o_in_ready), 1);
    idx = 0;
    budget = 0;
    while (o_busy && budget < 600) begin
      v = (idx < s_n) && ($urandom_range(99) >= stall_pct);
      if (idx < s_n) drive(v, s_opc[idx], s_adr[idx], s_last[idx]);
      else           drive(v, 3'($urandom), 5'($urandom), 1'($urandom));
      acc = v && o_in_ready;
      step();
      budget++;
      if (acc) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
    end
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();
    check({name, "_terminated"}, 32'(budget < 600), 1);
    k = 0;
    for (int i = 0; i < s_n; i++) begin
      k = i + 1;
      if (s_last[i] || k == MEM_DEPTH) break;
    end
    exp_ovf = (k == MEM_DEPTH) && !s_last[k-1];
    check({name, "_accepts"},  32'(acc_cyc.size()),     32'(k));
    check({name, "_writes"},   32'(wlog.size() - base), 32'(k));
    check({name, "_count"},    32'(o_count),            32'(k));
    check({name, "_overflow"}, 32'(o_overflow),         32'(exp_ovf));
    check({name, "_done_cnt"}, 32'(done_cnt - dbase),   1);
    if (acc_cyc.size() == k && k > 0)
      check({name, "_done_cyc"}, 32'(done_cyc), 32'(acc_cyc[k-1]));
    for (int i = 0; i < k && base + i < wlog.size() && i < acc_cyc.size(); i++) begin
      check($sformatf("%s_w%0d_addr", name, i), 32'(wlog[base+i].addr), 32'(i));
      check($sformatf("%s_w%0d_data", name, i), 32'(wlog[base+i].data), 32'({s_opc[i], s_adr[i]}));
      check($sformatf("%s_w%0d_cyc",  name, i), 32'(wlog[base+i].c),    32'(acc_cyc[i]));
    end
  endtask

  typedef struct {
    logic [2:0] opc;
    logic [4:0] adr;
    logic       last;
    logic [7:0] exp_data;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t basic[4];
    int   vpat[5];
    int   widx, base;

    basic[0] = '{3'b001, 5'd10, 1'b0, 8'h2A};
    basic[1] = '{3'b010, 5'd11, 1'b0, 8'h4B};
    basic[2] = '{3'b111, 5'd0,  1'b0, 8'hE0};
    basic[3] = '{3'b000, 5'd31, 1'b1, 8'h1F};
    vpat     = '{1, 0, 0, 1, 1};

    i_reset = 1'b1;
    i_start = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();
    step();
    check_reset_values("reset");
    i_reset = 1'b0;
    drive(1'b1, 3'd5, 5'd5, 1'b1);
    step();
    check("idle_ignores_valid", 32'(o_wr_en), 0);
    drive(1'b0, 3'd0, 5'd0, 1'b0);

    // Basic load from the vector table.
    pulse_start();
    check("basic_ready", 32'(o_in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, basic[i].opc, basic[i].adr, basic[i].last);
      step();
      check($sformatf("basic%0d_wr_en", i), 32'(o_wr_en),   1);
      check($sformatf("basic%0d_addr",  i), 32'(o_wr_addr), 32'(i));
      check($sformatf("basic%0d_data",  i), 32'(o_wr_data), 32'(basic[i].exp_data));
      check($sformatf("basic%0d_done",  i), 32'(o_done),    32'(basic[i].last));
      check($sformatf("basic%0d_count", i), 32'(o_count),   32'(i + 1));
    end
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();
    check("basic_busy_end",  32'(o_busy),     0);
    check("basic_done_end",  32'(o_done),     0);
    check("basic_wr_en_end", 32'(o_wr_en),    0);
    check("basic_count",     32'(o_count),    4);
    check("basic_overflow",  32'(o_overflow), 0);
    check("basic_hold_data", 32'(o_wr_data),  32'h1F);

    // Stalls: valid 1,0,0,1,1 carrying A1, A2, A3.
    pulse_start();
    widx = 0;
    for (int i = 0; i < 5; i++) begin
      if (vpat[i] != 0) drive(1'b1, 3'b101, 5'(widx + 1), widx == 2);
      else              drive(1'b0, 3'b000, 5'd0, 1'b0);
      step();
      check($sformatf("stall%0d_wr_en", i), 32'(o_wr_en), 32'(vpat[i]));
      if (vpat[i] != 0) begin
        check($sformatf("stall%0d_addr", i), 32'(o_wr_addr), 32'(widx));
        check($sformatf("stall%0d_data", i), 32'(o_wr_data), 32'(8'hA1 + widx));
        widx++;
      end
    end
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();
    check("stall_busy_end", 32'(o_busy),  0);
    check("stall_count",    32'(o_count), 3);

    // Reset mid-session with a fourth word offered on the reset edge.
    base = wlog.size();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(i), 5'(i + 5), 1'b0);
      step();
    end
    drive(1'b1, 3'd6, 5'd9, 1'b0);
    i_reset = 1'b1;
    step();
    check_reset_values("midreset");
    i_reset = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    repeat (3) step();
    check("midreset_writes", 32'(wlog.size() - base), 3);
    pulse_start();
    drive(1'b1, 3'd4, 5'd4, 1'b1);
    step();
    check("restart_wr_en", 32'(o_wr_en),   1);
    check("restart_addr",  32'(o_wr_addr), 0);
    check("restart_data",  32'(o_wr_data), 32'h84);
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();

    // Exact fit and overflow.
    fill(32, 31);
    run_session(0, "fit");
    fill(33, -1);
    run_session(0, "ovf");
    repeat (3) step();
    check("ovf_sticky",       32'(o_overflow), 1);
    check("ovf_count_hold",   32'(o_count),    32);
    pulse_start();
    check("ovf_clear_start",  32'(o_overflow), 0);
    check("count_clear_start",32'(o_count),    0);
    drive(1'b1, 3'd1, 5'd1, 1'b1);
    step();
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();

    // Start during LOAD is ignored.
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd2, 5'(i), 1'b0);
      step();
    end
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    pulse_start();
    check("ign_start_count", 32'(o_count),    2);
    check("ign_start_ready", 32'(o_in_ready), 1);
    drive(1'b1, 3'd3, 5'd7, 1'b1);
    step();
    check("ign_start_addr",  32'(o_wr_addr), 2);
    check("ign_start_cnt3",  32'(o_count),   3);
    drive(1'b0, 3'd0, 5'd0, 1'b0);
    step();

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      int n, li;
      n  = $urandom_range(1, 40);
      li = (n > 32 && $urandom_range(1) == 1) ? -1 : $urandom_range(n - 1);
      fill(n, li);
      run_session($urandom_range(60), $sformatf("rnd%0d", s));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
